// File: rtl/wasm_i64_alu_exec_if.sv
// rtl/wasm_i64_alu_exec_if.sv - opcode handshake and operand-stack port bundle for the i64 execute stage
interface wasm_i64_alu_exec_if #(
    parameter int ST_WIDTH = 64
);
    logic                op_valid;
    logic                op_ready;
    logic [7:0]          opcode;
    logic                st_push;
    logic                st_pop;
    logic [ST_WIDTH-1:0] st_push_data;
    logic [ST_WIDTH-1:0] st_pop_data;
    logic                st_empty;
    logic                done;
    logic                trap;

    modport master (
        output op_valid, opcode, st_pop_data, st_empty,
        input  op_ready, st_push, st_pop, st_push_data, done, trap
    );

    modport slave (
        input  op_valid, opcode, st_pop_data, st_empty,
        output op_ready, st_push, st_pop, st_push_data, done, trap
    );
endinterface

// File: rtl/wasm_i64_alu_exec.sv
// rtl/wasm_i64_alu_exec.sv - WebAssembly i64 numeric execute stage: pop operands, compute, push result
module wasm_i64_alu_exec #(
    parameter int ST_WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    wasm_i64_alu_exec_if.slave bus
);
    localparam int SH_W = $clog2(ST_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP_B = 3'd1,
        S_POP_A = 3'd2,
        S_EXEC  = 3'd3,
        S_PUSH  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [7:0]          op_q;
    logic [ST_WIDTH-1:0] a_q;
    logic [ST_WIDTH-1:0] b_q;
    logic [ST_WIDTH-1:0] res_q;
    logic [ST_WIDTH-1:0] alu_res;
    logic                accept;
    logic                op_known;
    logic [SH_W-1:0]     shamt;

    assign accept = (state == S_IDLE) && bus.op_valid;
    assign shamt  = b_q[SH_W-1:0];

    // Decode the incoming opcode byte against the supported i64 set
    always_comb begin
        op_known = 1'b0;
        case (bus.opcode)
            8'h50, 8'h51, 8'h52, 8'h53, 8'h54,
            8'h7C, 8'h7D, 8'h7E,
            8'h83, 8'h84, 8'h85,
            8'h86, 8'h87, 8'h88: op_known = 1'b1;
            default:             op_known = 1'b0;
        endcase
    end

    // Result datapath: a op b, compares and eqz yield a zero-extended flag
    always_comb begin
        alu_res = '0;
        case (op_q)
            8'h50:   alu_res[0] = (a_q == '0);
            8'h51:   alu_res[0] = (a_q == b_q);
            8'h52:   alu_res[0] = (a_q != b_q);
            8'h53:   alu_res[0] = ($signed(a_q) < $signed(b_q));
            8'h54:   alu_res[0] = (a_q < b_q);
            8'h7C:   alu_res = a_q + b_q;
            8'h7D:   alu_res = a_q - b_q;
            8'h7E:   alu_res = a_q * b_q;
            8'h83:   alu_res = a_q & b_q;
            8'h84:   alu_res = a_q | b_q;
            8'h85:   alu_res = a_q ^ b_q;
            8'h86:   alu_res = a_q << shamt;
            8'h87:   alu_res = $unsigned($signed(a_q) >>> shamt);
            8'h88:   alu_res = a_q >> shamt;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture opcode on accept, operands on each successful pop, result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                op_q <= bus.opcode;
            end
            if (state == S_POP_B && !bus.st_empty) begin
                b_q <= bus.st_pop_data;
            end
            if (state == S_POP_A && !bus.st_empty) begin
                a_q <= bus.st_pop_data;
            end
            if (state == S_EXEC) begin
                res_q <= alu_res;
            end
        end
    end

    // Next-state: eqz skips POP_B; underflow or unknown opcode parks in TRAP
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op_known)               state_nx = S_TRAP;
                    else if (bus.opcode == 8'h50) state_nx = S_POP_A;
                    else                         state_nx = S_POP_B;
                end
            end
            S_POP_B: state_nx = bus.st_empty ? S_TRAP : S_POP_A;
            S_POP_A: state_nx = bus.st_empty ? S_TRAP : S_EXEC;
            S_EXEC:  state_nx = S_PUSH;
            S_PUSH:  state_nx = S_IDLE;
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state so an async reset clears them immediately
    always_comb begin
        bus.op_ready     = (state == S_IDLE);
        bus.st_pop       = (state == S_POP_B || state == S_POP_A) && !bus.st_empty;
        bus.st_push      = (state == S_PUSH);
        bus.done         = (state == S_PUSH);
        bus.st_push_data = (state == S_PUSH) ? res_q : '0;
        bus.trap         = (state == S_TRAP);
    end
endmodule

// File: tb/tb_wasm_i64_alu_exec.sv
// tb/tb_wasm_i64_alu_exec.sv - directed-vector bench for the i64 execute stage with a stack model
module tb_wasm_i64_alu_exec;
    logic clk;
    logic rst_n;

    wasm_i64_alu_exec_if #(.ST_WIDTH(64)) bus ();

    wasm_i64_alu_exec #(.ST_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Stack model: bench preload/clear requests take priority over DUT strobes
    logic [63:0] mem [0:15];
    int          depth    = 0;
    int          n_pops   = 0;
    int          n_pushes = 0;
    int          n_both   = 0;
    logic        tb_push  = 1'b0;
    logic        tb_clear = 1'b0;
    logic [63:0] tb_val   = '0;

    assign bus.st_empty    = (depth == 0);
    assign bus.st_pop_data = (depth > 0) ? mem[depth-1] : 64'h0;

    always @(posedge clk) begin
        if (bus.st_push && bus.st_pop) n_both = n_both + 1;
        if (tb_clear) begin
            depth = 0;
        end else if (tb_push) begin
            mem[depth] = tb_val;
            depth = depth + 1;
        end else begin
            if (bus.st_pop && depth > 0) begin
                depth  = depth - 1;
                n_pops = n_pops + 1;
            end
            if (bus.st_push) begin
                mem[depth] = bus.st_push_data;
                depth    = depth + 1;
                n_pushes = n_pushes + 1;
            end
        end
    end

    task automatic push_val(input logic [63:0] v);
        @(negedge clk);
        tb_val  = v;
        tb_push = 1'b1;
        @(negedge clk);
        tb_push = 1'b0;
    endtask

    task automatic clear_stack();
        @(negedge clk);
        tb_clear = 1'b1;
        @(negedge clk);
        tb_clear = 1'b0;
        n_pops   = 0;
        n_pushes = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one opcode, return cycle index of done (0 if never) and pushed value
    task automatic issue(input logic [7:0] op, output int dcyc, output logic [63:0] dval);
        dcyc = 0;
        dval = '0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.opcode   = 8'h00;
        for (int n = 1; n <= 12; n++) begin
            if (bus.done && dcyc == 0) begin
                dcyc = n;
                dval = bus.st_push_data;
            end
            if (dcyc == 0) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  op;
        logic [63:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs [$];
    int          dc;
    logic [63:0] dv;

    initial begin
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.opcode   = 8'h00;
        #12;
        chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_push",     64'(bus.st_push),  64'd0);
        chk("rst_pop",      64'(bus.st_pop),   64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        chk("rst_trap",     64'(bus.trap),     64'd0);
        chk("rst_pdata",    bus.st_push_data,  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // sub with latency and post-op ready check
        push_val(64'd5);
        push_val(64'd3);
        issue(8'h7D, dc, dv);
        chk("sub_val",   dv, 64'd2);
        chk("sub_cycle", 64'(dc), 64'd4);
        @(negedge clk);
        chk("sub_ready5", 64'(bus.op_ready), 64'd1);
        chk("sub_depth",  64'(depth), 64'd1);
        chk("sub_top",    mem[0], 64'd2);
        chk("sub_pops",   64'(n_pops), 64'd2);
        clear_stack();

        // add wrap then eqz of the result
        push_val(64'hFFFF_FFFF_FFFF_FFFF);
        push_val(64'd1);
        issue(8'h7C, dc, dv);
        chk("add_wrap", dv, 64'd0);
        issue(8'h50, dc, dv);
        chk("eqz_val",   dv, 64'd1);
        chk("eqz_cycle", 64'(dc), 64'd3);
        @(negedge clk);
        chk("eqz_depth", 64'(depth), 64'd1);
        clear_stack();

        vecs.push_back('{64'h8000_0000_0000_0000, 64'h44, 8'h87, 64'hF800_0000_0000_0000, "shr_s"});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h44, 8'h88, 64'h0800_0000_0000_0000, "shr_u"});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,  8'h53, 64'h1, "lt_s"});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,  8'h54, 64'h0, "lt_u"});
        vecs.push_back('{64'h0000_0001_0000_0003, 64'h7F, 8'h86, 64'h8000_0000_0000_0000, "shl63"});
        vecs.push_back('{64'h0000_0000_0000_00F0, 64'h41, 8'h86, 64'h1E0, "shl_mask"});
        vecs.push_back('{64'h1_0000_0001, 64'h1_0000_0003, 8'h7E, 64'h4_0000_0003, "mul_lo"});
        vecs.push_back('{64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000, 8'h83, 64'h0F00_0F00_1234_0000, "and"});
        vecs.push_back('{64'hFF00_0000_0000_0001, 64'h00FF_0000_0000_0002, 8'h84, 64'hFFFF_0000_0000_0003, "or"});
        vecs.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000, 8'h85, 64'h5555_5555_AAAA_AAAA, "xor"});
        vecs.push_back('{64'd42, 64'd42, 8'h51, 64'd1, "eq"});
        vecs.push_back('{64'd42, 64'd42, 8'h52, 64'd0, "ne"});
        vecs.push_back('{64'd3,  64'd5,  8'h7D, 64'hFFFF_FFFF_FFFF_FFFE, "sub_neg"});
        foreach (vecs[i]) begin
            push_val(vecs[i].a);
            push_val(vecs[i].b);
            issue(vecs[i].op, dc, dv);
            chk(vecs[i].tag, dv, vecs[i].exp);
            clear_stack();
        end

        // Underflow on empty stack
        issue(8'h7C, dc, dv);
        repeat (3) @(negedge clk);
        chk("uf0_trap",  64'(bus.trap), 64'd1);
        chk("uf0_ready", 64'(bus.op_ready), 64'd0);
        chk("uf0_pops",  64'(n_pops), 64'd0);
        chk("uf0_done",  64'(dc), 64'd0);
        bus.op_valid = 1'b1;
        bus.opcode   = 8'h7C;
        repeat (4) @(negedge clk);
        bus.op_valid = 1'b0;
        chk("uf0_sticky", 64'(bus.trap), 64'd1);
        do_reset();
        clear_stack();

        // Underflow after one pop
        push_val(64'd9);
        issue(8'h7E, dc, dv);
        repeat (3) @(negedge clk);
        chk("uf1_trap",  64'(bus.trap), 64'd1);
        chk("uf1_pops",  64'(n_pops), 64'd1);
        chk("uf1_depth", 64'(depth), 64'd0);
        chk("uf1_push",  64'(n_pushes), 64'd0);
        do_reset();
        clear_stack();

        // Unsupported opcode traps the cycle after accept
        push_val(64'd1);
        push_val(64'd2);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = 8'h7F;
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("bad_op_trap", 64'(bus.trap), 64'd1);
        repeat (3) @(negedge clk);
        chk("bad_op_pops",  64'(n_pops), 64'd0);
        chk("bad_op_depth", 64'(depth), 64'd2);
        do_reset();
        clear_stack();

        // Reset while in POP_A
        push_val(64'd10);
        push_val(64'd20);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = 8'h7C;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("popa_strobe", 64'(bus.st_pop), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pop",   64'(bus.st_pop),  64'd0);
        chk("mid_rst_push",  64'(bus.st_push), 64'd0);
        chk("mid_rst_done",  64'(bus.done),    64'd0);
        chk("mid_rst_trap",  64'(bus.trap),    64'd0);
        chk("mid_rst_ready", 64'(bus.op_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_pushes", 64'(n_pushes), 64'd0);
        chk("after_rst_ready", 64'(bus.op_ready), 64'd1);
        clear_stack();
        push_val(64'd7);
        push_val(64'd8);
        issue(8'h7C, dc, dv);
        chk("after_rst_add",   dv, 64'd15);
        chk("after_rst_cycle", 64'(dc), 64'd4);

        chk("push_pop_overlap", 64'(n_both), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
